sram_sdram_bridge: RTL and testbench

- Sits between the MTX core's SRAM-style memory port and the SDRAM controller. It replaces the direct strobe-to-SDRAM wiring in the top level.
- Converts level strobes (active-low CE/OE/WE) into single-cycle SDRAM rd/we pulses and returns read data with a ready flag.
- Arbitrates ROM/VHD download writes against core accesses, buffering one download write.

---
 rtl/mtx_mem_pkg.sv | 19 +
 rtl/strobe_edge_sync.sv | 41 ++++
 rtl/sram_sdram_bridge.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sram_sdram_bridge.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtx_mem_pkg.sv
// Shared types and constants for the MTX memory bridge.
package mtx_mem_pkg;

    localparam int MTX_ADDR_W = 23;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACK,
        DONE,
        HOLD
    } bridge_state_t;

    typedef enum logic {
        ACC_RD,
        ACC_WR
    } access_t;

endpackage

// File: rtl/strobe_edge_sync.sv
// Turns the core's level strobes into a registered one-cycle request edge
// plus the access type captured at that edge (write wins over read).
module strobe_edge_sync
    import mtx_mem_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    n_ce_i,
    input  logic    n_oe_i,
    input  logic    n_we_i,
    output logic    req_o,
    output logic    edge_o,
    output access_t acc_o
);

    logic    req_q;
    logic    edge_q;
    access_t acc_q;
    logic    rise;

    assign req_o  = ~n_ce_i & (~n_oe_i | ~n_we_i);
    assign rise   = req_o & ~req_q;
    assign edge_o = edge_q;
    assign acc_o  = acc_q;

    // Remember last request level; emit a registered pulse and latch type on its rising edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q  <= 1'b0;
            edge_q <= 1'b0;
            acc_q  <= ACC_RD;
        end else begin
            req_q  <= req_o;
            edge_q <= rise;
            if (rise) begin
                acc_q <= (~n_we_i) ? ACC_WR : ACC_RD;
            end
        end
    end

endmodule

// File: rtl/sram_sdram_bridge.sv
// SRAM-style core port to SDRAM controller bridge with a one-deep download
// write buffer. Optional one-entry read cache enabled by BRIDGE_RDCACHE_EN.
module sram_sdram_bridge
    import mtx_mem_pkg::*;
#(
    parameter int ADDR_W      = MTX_ADDR_W,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              n_ce,
    input  logic              n_oe,
    input  logic              n_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [7:0]        core_din,
    output logic [7:0]        core_dout,
    output logic              core_rdy,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_overflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    output logic              ram_rd,
    input  logic [7:0]        ram_dout,
    input  logic              ram_ready
);

    localparam int               CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    bridge_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              seen_q, seen_d;

    logic              req;
    logic              edge_raw;
    access_t           edge_acc;
    logic              core_edge;
    logic              core_pend;
    access_t           core_acc;
    logic              pend_q;
    access_t           pend_acc_q;

    logic              hold_full_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [7:0]        hold_data_q;
    logic              overflow_q;

    logic              cur_dl_q;
    access_t           cur_acc_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_din_q;
    logic              ram_we_q;
    logic              ram_rd_q;
    logic [7:0]        core_dout_q;

    logic              start_dl;
    logic              start_core;
    logic              clear_hold;
    logic              hit;
    logic              cache_hit;
    logic [7:0]        rd_data;

    strobe_edge_sync u_edge (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .n_ce_i (n_ce),
        .n_oe_i (n_oe),
        .n_we_i (n_we),
        .req_o  (req),
        .edge_o (edge_raw),
        .acc_o  (edge_acc)
    );

    assign core_edge = edge_raw & ~dl_active;
    assign core_pend = pend_q | core_edge;
    assign core_acc  = pend_q ? pend_acc_q : edge_acc;

`ifdef BRIDGE_RDCACHE_EN
    logic              cache_valid_q;
    logic [ADDR_W-1:0] cache_addr_q;
    logic [7:0]        cache_data_q;
    logic              cur_hit_q;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    assign cache_hit = cache_valid_q && (cache_addr_q == core_addr);
    assign rd_data   = cur_hit_q ? cache_data_q : ram_dout;
    assign wr_start  = start_dl | (start_core & (core_acc == ACC_WR));
    assign wr_addr   = start_dl ? hold_addr_q : core_addr;
    assign wr_data   = start_dl ? hold_data_q : core_din;

    // Cache entry: filled by completed SDRAM reads, patched by writes, dropped during download
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= 8'h00;
            cur_hit_q     <= 1'b0;
        end else begin
            if (start_dl || start_core || hit) begin
                cur_hit_q <= hit;
            end
            if (dl_active) begin
                cache_valid_q <= 1'b0;
            end else if (state_q == DONE && !cur_dl_q && cur_acc_q == ACC_RD && !cur_hit_q) begin
                cache_valid_q <= 1'b1;
                cache_addr_q  <= ram_addr_q;
                cache_data_q  <= ram_dout;
            end else if (wr_start && cache_valid_q && cache_addr_q == wr_addr) begin
                cache_data_q <= wr_data;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign rd_data   = ram_dout;
`endif

    // Access sequencer: download buffer first, then core; waits for the controller handshake
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        start_dl   = 1'b0;
        start_core = 1'b0;
        clear_hold = 1'b0;
        hit        = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                seen_d = 1'b0;
                if (hold_full_q && ram_ready) begin
                    state_d  = ISSUE;
                    start_dl = 1'b1;
                end else if (core_pend && !dl_active) begin
                    if (core_acc == ACC_RD && cache_hit) begin
                        state_d = DONE;
                        hit     = 1'b1;
                    end else if (ram_ready) begin
                        state_d    = ISSUE;
                        start_core = 1'b1;
                    end
                end
            end
            ISSUE: begin
                clear_hold = cur_dl_q;
                if (!ram_ready) begin
                    seen_d = 1'b1;
                end
                state_d = ACK;
            end
            ACK: begin
                if (seen_q && ram_ready) begin
                    state_d = DONE;
                end else if (!ram_ready) begin
                    seen_d = 1'b1;
                end else if (!seen_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = cur_dl_q ? IDLE : HOLD;
            end
            HOLD: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, handshake counter and pending core edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_acc_q <= ACC_RD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            if (start_core || hit) begin
                pend_q <= 1'b0;
            end else if (core_edge) begin
                pend_q <= 1'b1;
            end
            if (core_edge) begin
                pend_acc_q <= edge_acc;
            end
        end
    end

    // Download holding register; a refill in the drain cycle is not an overflow
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            if (dl_wr) begin
                if (hold_full_q && !clear_hold) begin
                    overflow_q <= 1'b1;
                end else begin
                    hold_full_q <= 1'b1;
                    hold_addr_q <= dl_addr;
                    hold_data_q <= dl_data;
                end
            end else if (clear_hold) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    // SDRAM command outputs latched when an access starts; pulses live only in ISSUE
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ram_we_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 8'h00;
            cur_dl_q    <= 1'b0;
            cur_acc_q   <= ACC_RD;
            core_dout_q <= 8'h00;
        end else begin
            ram_we_q <= start_dl | (start_core & (core_acc == ACC_WR));
            ram_rd_q <= start_core & (core_acc == ACC_RD);
            if (start_dl) begin
                ram_addr_q <= hold_addr_q;
                ram_din_q  <= hold_data_q;
                cur_dl_q   <= 1'b1;
                cur_acc_q  <= ACC_WR;
            end else if (start_core) begin
                ram_addr_q <= core_addr;
                ram_din_q  <= core_din;
                cur_dl_q   <= 1'b0;
                cur_acc_q  <= core_acc;
            end else if (hit) begin
                cur_dl_q  <= 1'b0;
                cur_acc_q <= ACC_RD;
            end
            if (state_q == DONE && !cur_dl_q && cur_acc_q == ACC_RD) begin
                core_dout_q <= rd_data;
            end
        end
    end

    assign ram_we      = ram_we_q;
    assign ram_rd      = ram_rd_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign core_dout   = core_dout_q;
    assign core_rdy    = (state_q == HOLD) & ~dl_active;
    assign dl_overflow = overflow_q;

endmodule

// File: tb/tb_sram_sdram_bridge.sv
// Self-checking bench for sram_sdram_bridge: table of core accesses, download
// sequences, reset abort and the read-cache case, with a pulse scoreboard.
module tb_sram_sdram_bridge;
    import mtx_mem_pkg::*;

    localparam int AW = 23;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          n_ce, n_oe, n_we;
    logic [AW-1:0] core_addr;
    logic [7:0]    core_din;
    logic [7:0]    core_dout;
    logic          core_rdy;
    logic          dl_active, dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_overflow;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we, ram_rd;
    logic [7:0]    ram_dout;
    logic          ram_ready;

    sram_sdram_bridge #(.ADDR_W(AW), .ACK_TIMEOUT(4)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .n_ce        (n_ce),
        .n_oe        (n_oe),
        .n_we        (n_we),
        .core_addr   (core_addr),
        .core_din    (core_din),
        .core_dout   (core_dout),
        .core_rdy    (core_rdy),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_overflow (dl_overflow),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_rd      (ram_rd),
        .ram_dout    (ram_dout),
        .ram_ready   (ram_ready)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            isWr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } pulse_t;

    typedef struct {
        bit            isWr;
        bit            bothLow;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        int            busy;
        logic [7:0]    expDout;
    } vec_t;

    pulse_t     expQ[$];
    pulse_t     monExp;
    logic [7:0] mem [int];
    int         busyCycles = 3;
    int         busyCnt = 0;
    logic       prevPulse = 1'b0;

    // Compare one value and log a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // SDRAM controller model: stores writes, returns read data, busy for busyCycles after a pulse
    always @(posedge clk_sys) begin
        if (ram_we || ram_rd) begin
            if (ram_we) mem[int'(ram_addr)] = ram_din;
            if (ram_rd) ram_dout <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 8'hEE;
            if (busyCycles > 0) begin
                ram_ready <= 1'b0;
                busyCnt = busyCycles;
            end
        end else if (busyCnt > 0) begin
            busyCnt--;
            if (busyCnt == 0) ram_ready <= 1'b1;
        end
    end

    // Scoreboard monitor: every SDRAM pulse must match the next expected access and last one cycle
    always @(negedge clk_sys) begin
        if (!reset && (ram_we || ram_rd)) begin
            checkOutput("pulse_single_cycle", prevPulse, 0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got we=%0b rd=%0b addr=%0h, required no pulse",
                         ram_we, ram_rd, ram_addr);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("pulse_we", ram_we, monExp.isWr);
                checkOutput("pulse_rd", ram_rd, !monExp.isWr);
                checkOutput("pulse_addr", ram_addr, monExp.addr);
                if (monExp.isWr) checkOutput("pulse_data", ram_din, monExp.data);
            end
        end
        prevPulse = ram_we | ram_rd;
    end

    // Wait (bounded) for core_rdy, counting falling edges
    task automatic waitRdy(input int budget, output int cycles);
        cycles = 0;
        while (core_rdy !== 1'b1 && cycles < budget) begin
            @(negedge clk_sys);
            cycles++;
        end
    endtask

    // Start a core access and wait for it to complete
    task automatic applyStimulus(input bit isWr, input bit bothLow, input logic [AW-1:0] addr,
                                 input logic [7:0] wdata, input int busy, input bit expPulse,
                                 output int lat);
        pulse_t p;
        busyCycles = busy;
        p.isWr = isWr;
        p.addr = addr;
        p.data = wdata;
        if (expPulse) expQ.push_back(p);
        @(negedge clk_sys);
        core_addr = addr;
        core_din  = wdata;
        n_ce      = 1'b0;
        n_we      = !isWr;
        n_oe      = !(!isWr || bothLow);
        waitRdy(60, lat);
        checkOutput("core_rdy_rise", core_rdy, 1);
    endtask

    // Hold strobes for two cycles, release, and confirm core_rdy drops the next cycle
    task automatic releaseStrobes();
        repeat (2) begin
            @(negedge clk_sys);
            checkOutput("core_rdy_held", core_rdy, 1);
        end
        n_ce = 1'b1;
        n_oe = 1'b1;
        n_we = 1'b1;
        @(negedge clk_sys);
        checkOutput("core_rdy_release", core_rdy, 0);
        repeat (2) @(negedge clk_sys);
    endtask

    // Single-cycle download write, recorded as an expected SDRAM write
    task automatic dlWrite(input logic [AW-1:0] addr, input logic [7:0] data);
        pulse_t p;
        p.isWr = 1'b1;
        p.addr = addr;
        p.data = data;
        expQ.push_back(p);
        @(negedge clk_sys);
        dl_wr   = 1'b1;
        dl_addr = addr;
        dl_data = data;
        @(negedge clk_sys);
        dl_wr = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain
    task automatic waitQueueEmpty(input string name, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   lat;

        reset = 1'b1;
        n_ce = 1'b1; n_oe = 1'b1; n_we = 1'b1;
        core_addr = '0; core_din = 8'h00;
        dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = 8'h00;
        ram_ready = 1'b1; ram_dout = 8'h00;
        mem[32'h000100] = 8'hA5;
        mem[32'h001234] = 8'h77;

        vecs[0] = '{1'b0, 1'b0, 23'h000100, 8'h00, 3, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 23'h7FFFFF, 8'h3C, 2, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 23'h7FFFFF, 8'h00, 1, 8'h3C};
        vecs[3] = '{1'b1, 1'b0, 23'h000200, 8'hC3, 0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 23'h000200, 8'h00, 5, 8'hC3};
        vecs[5] = '{1'b0, 1'b0, 23'h000300, 8'h00, 2, 8'hEE};

        repeat (3) @(negedge clk_sys);
        checkOutput("reset_ram_we", ram_we, 0);
        checkOutput("reset_ram_rd", ram_rd, 0);
        checkOutput("reset_ram_addr", ram_addr, 0);
        checkOutput("reset_ram_din", ram_din, 0);
        checkOutput("reset_core_rdy", core_rdy, 0);
        checkOutput("reset_core_dout", core_dout, 0);
        checkOutput("reset_dl_overflow", dl_overflow, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].isWr, vecs[i].bothLow, vecs[i].addr, vecs[i].wdata,
                          vecs[i].busy, 1'b1, lat);
            if (!vecs[i].isWr) checkOutput("core_dout", core_dout, vecs[i].expDout);
            checkOutput("pulse_outstanding", expQ.size(), 0);
            releaseStrobes();
        end

        $display("[TB] download writes with ram_ready stuck high");
        busyCycles = 0;
        dl_active  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dlWrite(23'(k), 8'h10 + 8'(k));
            repeat (14) @(negedge clk_sys);
        end
        checkOutput("dl_drain", expQ.size(), 0);
        checkOutput("dl_overflow_clean", dl_overflow, 0);

        $display("[TB] download overflow while a write is in flight");
        busyCycles = 6;
        dlWrite(23'h000040, 8'h11);
        repeat (2) @(negedge clk_sys);
        begin
            pulse_t p;
            p.isWr = 1'b1;
            p.addr = 23'h000041;
            p.data = 8'h22;
            expQ.push_back(p);
        end
        dl_wr = 1'b1; dl_addr = 23'h000041; dl_data = 8'h22;
        @(negedge clk_sys);
        dl_wr = 1'b1; dl_addr = 23'h000042; dl_data = 8'h33;
        @(negedge clk_sys);
        dl_wr = 1'b0;
        checkOutput("dl_overflow_set", dl_overflow, 1);
        waitQueueEmpty("overflow_drain", 60);
        repeat (15) @(negedge clk_sys);
        checkOutput("dl_overflow_sticky", dl_overflow, 1);
        dl_active = 1'b0;
        repeat (2) @(negedge clk_sys);

        $display("[TB] reset during ACK");
        busyCycles = 10;
        begin
            pulse_t p;
            p.isWr = 1'b0;
            p.addr = 23'h000500;
            p.data = 8'h00;
            expQ.push_back(p);
        end
        @(negedge clk_sys);
        core_addr = 23'h000500; n_ce = 1'b0; n_oe = 1'b0; n_we = 1'b1;
        repeat (5) @(negedge clk_sys);
        reset = 1'b1;
        #1;
        checkOutput("abort_ram_rd", ram_rd, 0);
        checkOutput("abort_ram_we", ram_we, 0);
        checkOutput("abort_core_rdy", core_rdy, 0);
        checkOutput("abort_dl_overflow", dl_overflow, 0);
        checkOutput("abort_pulse_seen", expQ.size(), 0);
        n_ce = 1'b1; n_oe = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (12) @(negedge clk_sys);
        applyStimulus(1'b0, 1'b0, 23'h000100, 8'h00, 2, 1'b1, lat);
        checkOutput("post_reset_dout", core_dout, 8'hA5);
        releaseStrobes();

        $display("[TB] repeated read of 0x1234");
        applyStimulus(1'b0, 1'b0, 23'h001234, 8'h00, 2, 1'b1, lat);
        checkOutput("cache_first_dout", core_dout, 8'h77);
        releaseStrobes();
`ifdef BRIDGE_RDCACHE_EN
        applyStimulus(1'b0, 1'b0, 23'h001234, 8'h00, 2, 1'b0, lat);
        checkOutput("cache_hit_latency", lat, 3);
`else
        applyStimulus(1'b0, 1'b0, 23'h001234, 8'h00, 2, 1'b1, lat);
`endif
        checkOutput("cache_second_dout", core_dout, 8'h77);
        releaseStrobes();

        waitQueueEmpty("final_drain", 40);
        repeat (5) @(negedge clk_sys);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck run still ends with a report
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
